// File: rtl/eth_pkg.sv
// Shared Ethernet rx/tx definitions: FSM state encoding, framing bytes and CRC-32 constants.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } rx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    // Good-frame residue expressed in normal (MSB-first) bit order.
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    function automatic logic [31:0] bit_rev32(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rgmii_rx_framer_if.sv
// Rx byte bus from the RGMII capture stage and the framed byte stream towards the MAC.
interface rgmii_rx_framer_if;

    logic [7:0] rx_data;
    logic       rx_dv;
    logic       rx_er;

    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       err;

    // master: capture stage / consumer side; slave: the framer itself
    modport master (
        output rx_data, rx_dv, rx_er,
        input  data, valid, last, err
    );

    modport slave (
        input  rx_data, rx_dv, rx_er,
        output data, valid, last, err
    );

endinterface

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 next-state for one byte per cycle (LSB of the byte first).
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] next_c
);

    localparam logic [31:0] POLY_REFL = bit_rev32(CRC32_POLY);

    always_comb begin
        next_c = crc;
        for (int i = 0; i < 8; i++) begin
            if (next_c[0] ^ data[i]) begin
                next_c = (next_c >> 1) ^ POLY_REFL;
            end else begin
                next_c = next_c >> 1;
            end
        end
    end

endmodule

// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: strips preamble/SFD, streams frame bytes with valid/last/err, counts frames.
// Optional FCS checking is built when RGMII_RX_CRC_CHECK_EN is defined.
module rgmii_rx_framer
    import eth_pkg::*;
#(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1522,
    parameter int unsigned PRE_MIN = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    rgmii_rx_framer_if.slave bus,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 2);
    localparam int unsigned PRE_W = $clog2(PRE_MIN + 1) + 1;

    localparam logic [1:0] ST_IDLE     = 2'(IDLE);
    localparam logic [1:0] ST_PREAMBLE = 2'(PREAMBLE);
    localparam logic [1:0] ST_DATA     = 2'(DATA);
    localparam logic [1:0] ST_DROP     = 2'(DROP);

    logic [1:0]       state_q, state_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       hold_q, hold_d;
    logic             sticky_q, sticky_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             runt_c;
    logic             fcs_bad_c;

`ifdef RGMII_RX_CRC_CHECK_EN
    logic [31:0] crc_q;
    logic [31:0] crc_next_c;

    crc32_d8 u_crc (
        .crc    (crc_q),
        .data   (bus.rx_data),
        .next_c (crc_next_c)
    );

    // Seeded throughout the preamble so the first frame byte starts from INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC32_INIT;
        end else if (state_q == ST_PREAMBLE) begin
            crc_q <= CRC32_INIT;
        end else if (state_q == ST_DATA && bus.rx_dv) begin
            crc_q <= crc_next_c;
        end
    end

    assign fcs_bad_c = (bit_rev32(crc_q) != CRC32_RESIDUE);
`else
    assign fcs_bad_c = 1'b0;
`endif

    // len_q counts bytes loaded so far, so it is the frame length once dv falls.
    assign runt_c = (len_q < LEN_W'(MIN_LEN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pre_cnt_q   <= '0;
            len_q       <= '0;
            hold_q      <= '0;
            sticky_q    <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            len_q       <= len_d;
            hold_q      <= hold_d;
            sticky_q    <= sticky_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        len_d       = len_q;
        hold_d      = hold_q;
        sticky_d    = sticky_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        last_d      = 1'b0;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_dv) begin
                    if (bus.rx_data == PREAMBLE_BYTE) begin
                        state_d   = ST_PREAMBLE;
                        pre_cnt_d = PRE_W'(1);
                    end else begin
                        state_d   = ST_DROP;
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_PREAMBLE: begin
                if (!bus.rx_dv) begin
                    state_d = ST_IDLE;
                end else if (bus.rx_data == PREAMBLE_BYTE) begin
                    if (pre_cnt_q != '1) begin
                        pre_cnt_d = pre_cnt_q + PRE_W'(1);
                    end
                end else if (bus.rx_data == SFD_BYTE && pre_cnt_q >= PRE_W'(PRE_MIN)) begin
                    state_d  = ST_DATA;
                    len_d    = '0;
                    sticky_d = 1'b0;
                end else begin
                    state_d   = ST_DROP;
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (!bus.rx_dv) begin
                    state_d = ST_IDLE;
                    if (len_q == '0) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end else begin
                        data_d  = hold_q;
                        valid_d = 1'b1;
                        last_d  = 1'b1;
                        err_d   = sticky_q | runt_c | fcs_bad_c;
                        if (err_d) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end else begin
                            frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        end
                    end
                end else if (len_q == LEN_W'(MAX_LEN)) begin
                    // Byte MAX_LEN+1: close the frame as a giant and discard the rest.
                    state_d   = ST_DROP;
                    data_d    = hold_q;
                    valid_d   = 1'b1;
                    last_d    = 1'b1;
                    err_d     = 1'b1;
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end else begin
                    if (len_q != '0) begin
                        data_d  = hold_q;
                        valid_d = 1'b1;
                    end
                    hold_d   = bus.rx_data;
                    len_d    = len_q + LEN_W'(1);
                    sticky_d = sticky_q | bus.rx_er;
                end
            end

            ST_DROP: begin
                if (!bus.rx_dv) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.last  = last_q;
    assign bus.err   = err_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Directed self-checking bench for rgmii_rx_framer; expected values come from a bench-side FCS model.
module tb_rgmii_rx_framer;

    localparam int unsigned CNT_W = 16;
`ifdef RGMII_RX_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;

    rgmii_rx_framer_if bus ();

    rgmii_rx_framer #(
        .MIN_LEN (64),
        .MAX_LEN (1522),
        .PRE_MIN (1),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    logic [7:0] got_q[$];
    int         vcyc_q[$];
    int         lasts = 0;
    int         last_beat = 0;
    logic       last_err = 1'b0;
    logic [7:0] last_data = 8'h00;

    always @(negedge clk) begin
        if (rst_n && bus.valid) begin
            got_q.push_back(bus.data);
            vcyc_q.push_back(cyc);
            if (bus.last) begin
                lasts     = lasts + 1;
                last_beat = got_q.size();
                last_err  = bus.err;
                last_data = bus.data;
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    logic [7:0] seq[$];
    int         sfd_edge = 0;
    int         exp_frames = 0;
    int         exp_errs = 0;
    int         b_beats = 0;
    int         b_lasts = 0;

    // Preamble, SFD and n frame bytes; the final four are a valid FCS when fcs is set.
    task automatic build_frame(input int npre, input int n, input bit fcs, input int seed);
        logic [31:0] c;
        logic [7:0]  b;
        seq.delete();
        for (int i = 0; i < npre; i++) seq.push_back(8'h55);
        seq.push_back(8'hD5);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n - (fcs ? 4 : 0); i++) begin
            b = 8'(i * 7 + seed);
            seq.push_back(b);
            c = crc_upd(c, b);
        end
        if (fcs) begin
            c = ~c;
            for (int k = 0; k < 4; k++) begin
                seq.push_back(c[7:0]);
                c = c >> 8;
            end
        end
    endtask

    task automatic drive_seq(input int sfd_idx, input int er_idx, input int stop_after, input int gap);
        for (int i = 0; i < seq.size(); i++) begin
            @(posedge clk);
            #1;
            bus.rx_dv   = 1'b1;
            bus.rx_data = seq[i];
            bus.rx_er   = (i == er_idx);
            if (i == sfd_idx) sfd_edge = cyc + 1;
            if (i + 1 == stop_after) return;
        end
        @(posedge clk);
        #1;
        bus.rx_dv   = 1'b0;
        bus.rx_er   = 1'b0;
        bus.rx_data = 8'h00;
        for (int g = 1; g < gap; g++) @(posedge clk);
    endtask

    task automatic snap();
        b_beats = got_q.size();
        b_lasts = lasts;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic frame_checks(input string tag, input int nbeats, input int nlasts, input bit exp_e);
        check({tag, "_beats"}, 32'(got_q.size() - b_beats), 32'(nbeats));
        check({tag, "_lasts"}, 32'(lasts - b_lasts), 32'(nlasts));
        if (nlasts > 0) begin
            check({tag, "_last_pos"}, 32'(last_beat - b_beats), 32'(nbeats));
            check({tag, "_err"}, 32'(last_err), 32'(exp_e));
        end
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_errs));
    endtask

    initial begin
        bus.rx_dv   = 1'b0;
        bus.rx_er   = 1'b0;
        bus.rx_data = 8'h00;
        idle(3);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_last", 32'(bus.last), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_data", 32'(bus.data), 32'h0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        check("rst_err_cnt", 32'(err_cnt), 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Good 64-byte frame
        build_frame(7, 64, 1'b1, 3);
        snap();
        drive_seq(7, -1, 0, 3);
        idle(2);
        exp_frames++;
        frame_checks("good64", 64, 1, 1'b0);
        check("good64_latency", 32'(vcyc_q[b_beats] - sfd_edge), 32'd2);
        check("good64_first", 32'(got_q[b_beats]), 32'(seq[8]));
        check("good64_last_data", 32'(last_data), 32'(seq[seq.size() - 1]));

        // Same frame, one payload bit flipped
        build_frame(7, 64, 1'b1, 3);
        seq[13] = seq[13] ^ 8'h04;
        snap();
        drive_seq(7, -1, 0, 3);
        idle(2);
        if (CRC_EN) exp_errs++;
        else exp_frames++;
        frame_checks("bitflip", 64, 1, CRC_EN);

        // Runt
        build_frame(7, 40, 1'b1, 11);
        snap();
        drive_seq(7, -1, 0, 3);
        idle(2);
        exp_errs++;
        frame_checks("runt40", 40, 1, 1'b1);

        // rx_er on frame byte 10 of a good 100-byte frame
        build_frame(7, 100, 1'b1, 5);
        snap();
        drive_seq(7, 7 + 10, 0, 3);
        idle(2);
        exp_errs++;
        frame_checks("rxer100", 100, 1, 1'b1);

        // Giant
        build_frame(7, 1600, 1'b0, 1);
        snap();
        drive_seq(7, -1, 0, 3);
        idle(2);
        exp_errs++;
        frame_checks("giant", 1522, 1, 1'b1);

        // Bad preamble byte
        seq.delete();
        seq.push_back(8'h55); seq.push_back(8'h55); seq.push_back(8'hAA); seq.push_back(8'hD5);
        seq.push_back(8'h12); seq.push_back(8'h34);
        snap();
        drive_seq(-1, -1, 0, 3);
        idle(2);
        exp_errs++;
        frame_checks("bad_pre", 0, 0, 1'b0);

        // SFD without preamble
        seq.delete();
        seq.push_back(8'hD5); seq.push_back(8'h01); seq.push_back(8'h02);
        snap();
        drive_seq(-1, -1, 0, 3);
        idle(2);
        exp_errs++;
        frame_checks("no_pre", 0, 0, 1'b0);

        // Preamble only
        seq.delete();
        for (int i = 0; i < 5; i++) seq.push_back(8'h55);
        snap();
        drive_seq(-1, -1, 0, 3);
        idle(2);
        frame_checks("pre_only", 0, 0, 1'b0);

        // SFD immediately followed by dv low
        seq.delete();
        seq.push_back(8'h55); seq.push_back(8'hD5);
        snap();
        drive_seq(-1, -1, 0, 3);
        idle(2);
        exp_errs++;
        frame_checks("empty", 0, 0, 1'b0);

        // Back-to-back frames with a single idle cycle
        snap();
        build_frame(7, 64, 1'b1, 21);
        drive_seq(7, -1, 0, 1);
        build_frame(7, 64, 1'b1, 42);
        drive_seq(7, -1, 0, 3);
        idle(2);
        exp_frames += 2;
        frame_checks("b2b", 128, 2, 1'b0);

        // Reset during byte 30 of a third frame
        build_frame(7, 64, 1'b1, 9);
        snap();
        drive_seq(7, -1, 8 + 30, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.valid), 32'h0);
        check("midrst_last", 32'(bus.last), 32'h0);
        check("midrst_err", 32'(bus.err), 32'h0);
        check("midrst_data", 32'(bus.data), 32'h0);
        check("midrst_frame_cnt", 32'(frame_cnt), 32'h0);
        check("midrst_err_cnt", 32'(err_cnt), 32'h0);
        bus.rx_dv = 1'b0;
        idle(3);
        check("midrst_lasts", 32'(lasts - b_lasts), 32'h0);
        check("midrst_beats", 32'(got_q.size() - b_beats), 32'd28);
        check("midrst_hold_valid", 32'(bus.valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
